// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag sequencer for an external FIFO storage RAM.
// Drives the RAM write/read strobes and addresses. Data never passes through this block.
module fifo_ctrl #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 2**8 - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic             ram_write_enable_o,
  output logic             ram_valid_write_o,
  output logic [DEPTH-1:0] ram_write_address_o,
  output logic             ram_read_enable_o,
  output logic [DEPTH-1:0] ram_read_address_o,
  output logic [DEPTH:0]   count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  // state    | meaning
  // S_EMPTY  | no entries held
  // S_ACTIVE | 1 .. 2**DEPTH-1 entries held
  // S_FULL   | 2**DEPTH entries held
  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  localparam logic [DEPTH:0] CAP    = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] AF_LVL = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_LVL = (DEPTH+1)'(AE_LEVEL);

  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             almost_full_q, almost_empty_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_acc, rd_acc;

  assign full  = (state_q == S_FULL);
  assign empty = (state_q == S_EMPTY);

  // clear blocks both acceptances so a flush cycle never strobes the RAM.
  assign wr_acc = push_i & (~full | pop_i) & ~clear_i;
  assign rd_acc = pop_i & ~empty & ~clear_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      state_d     = S_EMPTY;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push_i && !wr_acc) overflow_d  = 1'b1;
      if (pop_i && !rd_acc)  underflow_d = 1'b1;
      case (state_q)
        S_EMPTY:  if (wr_acc) state_d = S_ACTIVE;
        S_ACTIVE: begin
          if (count_d == CAP)     state_d = S_FULL;
          else if (count_d == '0) state_d = S_EMPTY;
        end
        S_FULL:   if (rd_acc && !wr_acc) state_d = S_ACTIVE;
        default:  state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_EMPTY;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      almost_full_q  <= (count_d >= AF_LVL);
      almost_empty_q <= (count_d <= AE_LVL);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Strobes are held inactive for the whole reset pulse, not just after it.
  assign ram_write_enable_o  = reset_i | ~wr_acc;
  assign ram_valid_write_o   = ~reset_i & wr_acc;
  assign ram_read_enable_o   = reset_i | empty;
  assign ram_write_address_o = wr_ptr_q;
  assign ram_read_address_o  = rd_ptr_q;

  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = almost_full_q;
  assign almost_empty_o = almost_empty_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Sequencing controller for the single-port-write / async-read FIFO storage RAM; the RAM itself is a separate block.
- Owns the write/read pointers, occupancy count, status flags and sticky error flags.
- Generates the RAM's active-low write/read enables, write qualifier and addresses from a push/pop request interface.
- Data flows directly between the producer/consumer and the RAM; this block never touches data.

Parameters:
- DEPTH, 8: address width in bits; capacity is 2**DEPTH entries (matches the RAM's DEPTH).
- AF_LEVEL, 2**8-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  producer requests a write this cycle.
- pop  in  1  consumer requests removal of the head entry this cycle.
- clear  in  1  synchronous flush; pointers and count return to 0.
- ram_write_enable  out  1  active-low RAM write enable.
- ram_valid_write  out  1  RAM write qualifier; high with an accepted push.
- ram_write_address  out  DEPTH  RAM write address, equal to wr_ptr.
- ram_read_enable  out  1  active-low RAM read enable; low when not empty, so head data is driven.
- ram_read_address  out  DEPTH  RAM read address, equal to rd_ptr.
- count  out  DEPTH+1  occupancy, 0 to 2**DEPTH.
- full, empty  out  1 each  status flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Internal state: wr_ptr, rd_ptr (DEPTH bits, wrap modulo 2**DEPTH), count (DEPTH+1 bits), 2-bit FSM state.
- FSM states: S_EMPTY, S_ACTIVE, S_FULL.
- Registered outputs and reset values (reset asserted asynchronously):
  - wr_ptr = rd_ptr = 0, count = 0, state = S_EMPTY.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
- Combinational RAM strobes, all forced inactive while reset is high:
  - ram_write_enable = 1, ram_valid_write = 0, ram_read_enable = 1 during reset.
- Acceptance (combinational):
  - wr_acc = push & (!full | pop).
  - rd_acc = pop & !empty.
- RAM drive:
  - ram_valid_write = wr_acc; ram_write_enable = !wr_acc.
  - ram_read_enable = empty (low whenever data is present).
  - Addresses are the raw pointers.
- Show-ahead read: head data is valid at the RAM output in the same cycle empty = 0. Pop consumes it at the clock edge; zero read latency.
- Write latency: data presented with an accepted push is stored at that edge. It becomes visible as head no earlier than the next cycle, because empty deasserts at that edge.
- Per edge:
  - wr_acc: wr_ptr += 1.
  - rd_acc: rd_ptr += 1.
  - count += wr_acc - rd_acc.
  - Flags are derived from the next count and registered.
- Transitions:
  - S_EMPTY -> S_ACTIVE on wr_acc.
  - S_ACTIVE -> S_FULL when next count = 2**DEPTH.
  - S_ACTIVE -> S_EMPTY when next count = 0.
  - S_FULL -> S_ACTIVE on rd_acc without wr_acc.
  - empty == (state == S_EMPTY); full == (state == S_FULL).
- Simultaneous push+pop:
  - Non-empty, non-full: both accepted, count unchanged.
  - Full: both accepted. The write lands on the slot being consumed; the read sees old data before the edge. State stays S_FULL.
  - Empty: push accepted, pop rejected and underflow set. No bypass.
- Push when full without pop: rejected, no RAM write, overflow set.
- Pop when empty: rejected, underflow set.
- Sticky errors: overflow and underflow hold until reset or clear.
- clear:
  - Has priority over push/pop in the same cycle; no RAM write that cycle (ram_valid_write = 0).
  - Pointers and count go to 0, state to S_EMPTY, sticky errors clear.
- Wrap-around: pointers roll 2**DEPTH-1 -> 0 with no flag side effects.
- Full vs empty is resolved by count/state, never by pointer equality alone.
- Reset mid-operation: everything returns to reset values immediately and asynchronously; RAM contents are not cleared and are treated as stale.

Test Plan (DEPTH=2, AF_LEVEL=3, AE_LEVEL=1):
- Reset then idle -> empty=1, full=0, count=0, ram_read_enable=1, ram_write_enable=1, ram_valid_write=0.
- 4 pushes (data A,B,C,D) -> write addresses 0,1,2,3. count 1,2,3,4; almost_full at count 3; full=1 after the 4th edge. A 5th push gives ram_valid_write=0 and overflow=1.
- From full, 4 pops -> ram_read_address 0,1,2,3 with head data A,B,C,D on each pop cycle. empty=1 after the 4th edge. A 5th pop sets underflow=1 and leaves count at 0.
- Pointer wrap: 3 pushes, 3 pops, then 3 pushes -> write addresses 3,0,1. count=3; empty and full both stay 0.
- Full plus simultaneous push+pop for 2 cycles -> both accepted each cycle, count stays 4, full stays 1. Writes land on addresses 0 and 1 while the reads return the old data there.
- Empty plus push+pop -> count=1, underflow=1. Then clear together with push -> count=0, empty=1, errors cleared, no write strobe. Async reset pulse mid-burst -> immediate empty=1, count=0.
